reg_writeback_unit: RTL and testbench

//  Write-back end of the register-file interface. Owns the 32x32 GPR array and
//  per-register pending-write scoreboard. Decode reads operands and busy flags

---
 rtl/reg_writeback_unit.sv | 99 +++++++++
 tb/tb_reg_writeback_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// GPR file with write-back port, bypassed decode reads and a
// per-register pending-write scoreboard.
module reg_writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  output logic                        issue_ready,
  input  logic [$clog2(NUM_REGS)-1:0] RsD,
  input  logic [$clog2(NUM_REGS)-1:0] RtD,
  output logic [DATA_WIDTH-1:0]       data1,
  output logic [DATA_WIDTH-1:0]       data2,
  output logic                        flag1,
  output logic                        flag2,
  input  logic                        wb_valid,
  input  logic                        RegWriteW,
  input  logic                        MemToRegW,
  input  logic [DATA_WIDTH-1:0]       ReadDataW,
  input  logic [DATA_WIDTH-1:0]       ALUOutW,
  input  logic [$clog2(NUM_REGS)-1:0] WriteRegW,
  output logic [DATA_WIDTH-1:0]       ResultW,
  output logic                        wb_underflow
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] gpr_q  [NUM_REGS];
  logic [CNT_WIDTH-1:0]  pend_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  pend_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] result_q;
  logic                  uf_q;

  logic                  wb_fire;
  logic                  iss_fire;
  logic                  dec;
  logic [DATA_WIDTH-1:0] res;

  assign wb_fire  = wb_valid & RegWriteW & (WriteRegW != '0);
  assign res      = MemToRegW ? ReadDataW : ALUOutW;
  assign dec      = wb_fire & (pend_q[WriteRegW] != '0);

  // A retiring write frees a slot on a saturated register this cycle.
  assign issue_ready = ~((issue_rd != '0)
                       & (pend_q[issue_rd] == CNT_MAX)
                       & ~(dec & (WriteRegW == issue_rd)));
  assign iss_fire = issue_valid & issue_ready & (issue_rd != '0);

  assign data1 = (RsD == '0) ? '0 :
                 (wb_fire & (WriteRegW == RsD)) ? res : gpr_q[RsD];
  assign data2 = (RtD == '0) ? '0 :
                 (wb_fire & (WriteRegW == RtD)) ? res : gpr_q[RtD];

  assign flag1 = (RsD == '0) | (pend_q[RsD] == '0)
               | ((pend_q[RsD] == CNT_ONE) & dec & (WriteRegW == RsD));
  assign flag2 = (RtD == '0) | (pend_q[RtD] == '0)
               | ((pend_q[RtD] == CNT_ONE) & dec & (WriteRegW == RtD));

  assign ResultW      = result_q;
  assign wb_underflow = uf_q;

  always_comb begin
    pend_d = pend_q;
    if (!(iss_fire && dec && (issue_rd == WriteRegW))) begin
      if (iss_fire)
        pend_d[issue_rd] = pend_q[issue_rd] + CNT_ONE;
      if (dec)
        pend_d[WriteRegW] = pend_q[WriteRegW] - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i]  <= '0;
        pend_q[i] <= '0;
      end
      result_q <= '0;
      uf_q     <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wb_fire) begin
        gpr_q[WriteRegW] <= res;
        result_q         <= res;
      end
      if (wb_fire && (pend_q[WriteRegW] == '0))
        uf_q <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{IW};

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed table-driven bench for reg_writeback_unit.
// Each row is one cycle; outputs are checked before the next edge.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  RsD, RtD;
  logic [31:0] data1, data2;
  logic        flag1, flag2;
  logic        wb_valid, RegWriteW, MemToRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        wb_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .RsD(RsD), .RtD(RtD),
    .data1(data1), .data2(data2),
    .flag1(flag1), .flag2(flag2),
    .wb_valid(wb_valid), .RegWriteW(RegWriteW),
    .MemToRegW(MemToRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .wb_underflow(wb_underflow)
  );

  typedef struct {
    logic        rst;
    logic        chk;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wbv;
    logic        rw;
    logic        m2r;
    logic [31:0] rdd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        e_rdy;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_f1;
    logic        e_f2;
    logic [31:0] e_res;
    logic        e_uf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic rst, logic chk, logic iv, logic [4:0] ird,
    logic [4:0] rs, logic [4:0] rt,
    logic wbv, logic rw, logic m2r,
    logic [31:0] rdd, logic [31:0] alu, logic [4:0] wreg,
    logic e_rdy, logic [31:0] e_d1, logic [31:0] e_d2,
    logic e_f1, logic e_f2, logic [31:0] e_res, logic e_uf);
    vec_t v;
    v.rst = rst; v.chk = chk; v.iv = iv; v.ird = ird;
    v.rs = rs; v.rt = rt; v.wbv = wbv; v.rw = rw; v.m2r = m2r;
    v.rdd = rdd; v.alu = alu; v.wreg = wreg;
    v.e_rdy = e_rdy; v.e_d1 = e_d1; v.e_d2 = e_d2;
    v.e_f1 = e_f1; v.e_f2 = e_f2; v.e_res = e_res; v.e_uf = e_uf;
    return v;
  endfunction

  task automatic chk(string n, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", n, row, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset       = v.rst;
    issue_valid = v.iv;
    issue_rd    = v.ird;
    RsD         = v.rs;
    RtD         = v.rt;
    wb_valid    = v.wbv;
    RegWriteW   = v.rw;
    MemToRegW   = v.m2r;
    ReadDataW   = v.rdd;
    ALUOutW     = v.alu;
    WriteRegW   = v.wreg;
  endtask

  task automatic apply(vec_t v, int row);
    @(negedge clk);
    drive(v);
    #2;
    if (v.chk) begin
      chk("issue_ready", row, 32'(issue_ready), 32'(v.e_rdy));
      chk("data1", row, data1, v.e_d1);
      chk("data2", row, data2, v.e_d2);
      chk("flag1", row, 32'(flag1), 32'(v.e_f1));
      chk("flag2", row, 32'(flag2), 32'(v.e_f2));
      chk("ResultW", row, ResultW, v.e_res);
      chk("wb_underflow", row, 32'(wb_underflow), 32'(v.e_uf));
    end
  endtask

  localparam logic [31:0] DB = 32'hdeadbeef;

  initial begin
    // reset
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0, 0,0,0,     1,0,0,1,1,0,0));
    // 1: idle read after reset
    tbl.push_back(mk(0,1, 0,0, 5,0, 0,0,0, 0,0,0,     1,0,0,1,1,0,0));
    // 2: issue r3, then retire 0x1234 with bypass
    tbl.push_back(mk(0,1, 1,3, 3,0, 0,0,0, 0,0,0,     1,0,0,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 3,0, 0,0,0, 0,0,0,     1,0,0,0,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 3,0, 1,1,0, 0,32'h1234,3, 1,32'h1234,0,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 3,0, 0,0,0, 0,0,0,     1,32'h1234,0,1,1,32'h1234,0));
    // 3: saturate r7
    tbl.push_back(mk(0,1, 1,7, 7,0, 0,0,0, 0,0,0,     1,0,0,1,1,32'h1234,0));
    tbl.push_back(mk(0,1, 1,7, 7,0, 0,0,0, 0,0,0,     1,0,0,0,1,32'h1234,0));
    tbl.push_back(mk(0,1, 1,7, 7,0, 0,0,0, 0,0,0,     1,0,0,0,1,32'h1234,0));
    tbl.push_back(mk(0,1, 0,7, 7,0, 0,0,0, 0,0,0,     0,0,0,0,1,32'h1234,0));
    tbl.push_back(mk(0,1, 1,7, 7,0, 1,1,0, 0,32'h77,7, 1,32'h77,0,0,1,32'h1234,0));
    tbl.push_back(mk(0,1, 0,7, 7,0, 0,0,0, 0,0,0,     0,32'h77,0,0,1,32'h77,0));
    tbl.push_back(mk(0,1, 0,7, 7,0, 1,1,0, 0,32'h70,7, 1,32'h70,0,0,1,32'h77,0));
    tbl.push_back(mk(0,1, 0,0, 7,0, 1,1,0, 0,32'h71,7, 1,32'h71,0,0,1,32'h70,0));
    tbl.push_back(mk(0,1, 0,0, 7,0, 1,1,0, 0,32'h72,7, 1,32'h72,0,1,1,32'h71,0));
    tbl.push_back(mk(0,1, 0,0, 7,0, 0,0,0, 0,0,0,     1,32'h72,0,1,1,32'h72,0));
    // 4: issue and retire r9 in the same cycle
    tbl.push_back(mk(0,1, 1,9, 9,0, 0,0,0, 0,0,0,     1,0,0,1,1,32'h72,0));
    tbl.push_back(mk(0,1, 1,9, 9,9, 1,1,0, 0,32'h99,9, 1,32'h99,32'h99,1,1,32'h72,0));
    tbl.push_back(mk(0,1, 0,0, 9,0, 0,0,0, 0,0,0,     1,32'h99,0,0,1,32'h99,0));
    tbl.push_back(mk(0,1, 0,0, 9,0, 1,1,0, 0,32'h9a,9, 1,32'h9a,0,1,1,32'h99,0));
    tbl.push_back(mk(0,1, 0,0, 9,0, 0,0,0, 0,0,0,     1,32'h9a,0,1,1,32'h9a,0));
    // 5: underflow load to r4, then r0 and gated writes
    tbl.push_back(mk(0,1, 0,0, 4,0, 1,1,1, DB,32'h5555,4, 1,DB,0,1,1,32'h9a,0));
    tbl.push_back(mk(0,1, 0,0, 4,0, 0,0,0, 0,0,0,     1,DB,0,1,1,DB,1));
    tbl.push_back(mk(0,1, 0,0, 0,4, 1,1,0, 0,32'hffff,0, 1,0,DB,1,1,DB,1));
    tbl.push_back(mk(0,1, 0,0, 0,4, 0,0,0, 0,0,0,     1,0,DB,1,1,DB,1));
    tbl.push_back(mk(0,1, 0,0, 5,0, 0,1,0, 0,32'h55,5, 1,0,0,1,1,DB,1));
    tbl.push_back(mk(0,1, 0,0, 5,0, 1,0,0, 0,32'h56,5, 1,0,0,1,1,DB,1));
    tbl.push_back(mk(0,1, 0,0, 5,0, 0,0,0, 0,0,0,     1,0,0,1,1,DB,1));

    foreach (tbl[i]) apply(tbl[i], i);

    // 6: reset with r2 written and saturated
    @(negedge clk);
    reset = 0; issue_valid = 0; issue_rd = 0; RsD = 2; RtD = 2;
    wb_valid = 1; RegWriteW = 1; MemToRegW = 0;
    ALUOutW = 32'h22; WriteRegW = 2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wb_valid = 0; issue_valid = 1; issue_rd = 2;
    end
    @(negedge clk);
    issue_valid = 0;
    #2;
    chk("sat_ready_r2", 100, 32'(issue_ready), 32'd0);
    chk("sat_flag2_r2", 100, 32'(flag2), 32'd0);
    chk("pre_data1_r2", 100, data1, 32'h22);
    @(negedge clk);
    reset = 1; wb_valid = 1; ALUOutW = 32'hbad; WriteRegW = 2;
    issue_valid = 1;
    @(negedge clk);
    reset = 0; wb_valid = 0; issue_valid = 0; issue_rd = 2;
    #2;
    chk("rst_ready_r2", 101, 32'(issue_ready), 32'd1);
    chk("rst_flag1_r2", 101, 32'(flag1), 32'd1);
    chk("rst_data1_r2", 101, data1, 32'd0);
    chk("rst_uf", 101, 32'(wb_underflow), 32'd0);
    chk("rst_resultw", 101, ResultW, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
